// File: rtl/regfile_writeback_pkg.sv
// rtl/regfile_writeback_pkg.sv - shared constants and types for the writeback block
package regfile_writeback_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;

  // Register x0 is architecturally zero: never busy, never written.
  localparam int ZERO_REG = 0;

  typedef enum logic {
    GNT_EXU = 1'b0,
    GNT_LSU = 1'b1
  } gnt_src_e;

endpackage

// File: rtl/regfile_writeback_wb_rr_arbiter.sv
// rtl/regfile_writeback_wb_rr_arbiter.sv - two-way round-robin writeback arbiter
module wb_rr_arbiter
  import regfile_writeback_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     exu_valid,
  input  logic     lsu_valid,
  output logic     exu_gnt,
  output logic     lsu_gnt,
  output gnt_src_e sel
);

  gnt_src_e last_grant;

  // Pick the winner: a lone requester wins, contention goes to whoever lost last time.
  always_comb begin
    sel = GNT_EXU;
    if (exu_valid && lsu_valid) begin
      sel = (last_grant == GNT_EXU) ? GNT_LSU : GNT_EXU;
    end else if (lsu_valid) begin
      sel = GNT_LSU;
    end
    exu_gnt = exu_valid && (sel == GNT_EXU);
    lsu_gnt = lsu_valid && (sel == GNT_LSU);
  end

  // Remember the latest winner; reset favours LSU on the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_EXU;
    end else if (exu_gnt || lsu_gnt) begin
      last_grant <= sel;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register file write owner with busy scoreboard
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  exu_valid,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  output logic                  exu_ready,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] query_rs1,
  input  logic [ADDR_WIDTH-1:0] query_rs2,
  output logic                  busy_rs1,
  output logic                  busy_rs2,
  output logic                  wb_err
);

  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_nxt;
  logic                  grant;
  logic                  err_hit;
  logic [ADDR_WIDTH-1:0] win_rd;
  logic [DATA_WIDTH-1:0] win_data;
  gnt_src_e              sel;

  wb_rr_arbiter u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .exu_valid (exu_valid),
    .lsu_valid (lsu_valid),
    .exu_gnt   (exu_ready),
    .lsu_gnt   (lsu_ready),
    .sel       (sel)
  );

  // Scoreboard lookups, winner mux and the unexpected-write detector.
  always_comb begin
    busy_rs1    = busy[query_rs1];
    busy_rs2    = busy[query_rs2];
    issue_ready = (issue_rd == ZERO_IDX) || !busy[issue_rd];
    grant       = exu_ready || lsu_ready;
    win_rd      = (sel == GNT_LSU) ? lsu_rd : exu_rd;
    win_data    = (sel == GNT_LSU) ? lsu_data : exu_data;
    err_hit     = grant && (win_rd != ZERO_IDX) && !busy[win_rd];
  end

  // Next scoreboard: drop the register being committed now, mark the newly claimed one.
  always_comb begin
    busy_nxt = busy;
    if (rf_wen) begin
      busy_nxt[rf_waddr] = 1'b0;
    end
    if (issue_valid && issue_ready) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[ZERO_REG] = 1'b0;
  end

  // Scoreboard, registered write port and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_err   <= 1'b0;
    end else begin
      busy   <= busy_nxt;
      rf_wen <= grant && (win_rd != ZERO_IDX);
      if (grant) begin
        rf_waddr <= win_rd;
        rf_wdata <= win_data;
      end
      if (err_hit) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - scoreboard bench for regfile_writeback
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_ready;
  logic        exu_valid = 1'b0;
  logic [4:0]  exu_rd = '0;
  logic [31:0] exu_data = '0;
  logic        exu_ready;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        lsu_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  query_rs1 = '0;
  logic [4:0]  query_rs2 = '0;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        wb_err;

  regfile_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model: set of pending registers, last arbitration winner, sticky error.
  bit          m_busy[32];
  bit          m_last_lsu;
  bit          m_err;
  bit          m_pend;
  logic [4:0]  m_pend_rd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_last_lsu = 1'b0;
    m_err = 1'b0;
    m_pend = 1'b0;
    m_pend_rd = '0;
    exp_q.delete();
  endtask

  // Monitor: every cycle the write port must match the front of the expected-write queue.
  always @(negedge clk) begin
    if (rst_n) begin
      bit exp_wen;
      exp_wen = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("rf_wen", rf_wen, exp_wen);
      if (exp_wen) begin
        wr_t w;
        w = exp_q.pop_front();
        chk("rf_waddr", rf_waddr, w.addr);
        chk("rf_wdata", rf_wdata, w.data);
      end
    end
  end

  task automatic drive(input bit iv, input logic [4:0] ird,
                       input bit ev, input logic [4:0] erd, input logic [31:0] ed,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
    issue_valid = iv; issue_rd = ird;
    exu_valid = ev; exu_rd = erd; exu_data = ed;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One cycle: check combinational outputs mid-cycle, then advance the model past the edge.
  task automatic tick(input logic [4:0] q1, input logic [4:0] q2);
    bit ge, gl, acc;
    logic [4:0] rd;
    logic [31:0] d;
    query_rs1 = q1;
    query_rs2 = q2;
    @(negedge clk);
    ge = exu_valid && (!lsu_valid || m_last_lsu);
    gl = lsu_valid && (!exu_valid || !m_last_lsu);
    acc = issue_valid && ((issue_rd == 0) || !m_busy[issue_rd]);
    chk("issue_ready", issue_ready, (issue_rd == 0) || !m_busy[issue_rd]);
    chk("exu_ready", exu_ready, ge);
    chk("lsu_ready", lsu_ready, gl);
    chk("busy_rs1", busy_rs1, m_busy[q1]);
    chk("busy_rs2", busy_rs2, m_busy[q2]);
    chk("wb_err", wb_err, m_err);
    rd = gl ? lsu_rd : exu_rd;
    d = gl ? lsu_data : exu_data;
    if (m_pend) m_busy[m_pend_rd] = 1'b0;
    m_pend = 1'b0;
    if (ge || gl) begin
      m_last_lsu = gl;
      if (rd != 0) begin
        if (!m_busy[rd] && !(m_pend_rd == rd && 1'b0)) m_err = m_err;
        exp_q.push_back('{cyc + 1, rd, d});
        m_pend = 1'b1;
        m_pend_rd = rd;
      end
    end
    @(posedge clk);
    #1;
    if (acc && issue_rd != 0) m_busy[issue_rd] = 1'b1;
  endtask

  // Error rule uses the scoreboard state before this cycle's clear/set.
  function automatic bit err_cond(input bit ge, input bit gl, input logic [4:0] rd,
                                  input bit pend, input logic [4:0] prd);
    return (ge || gl) && (rd != 0) && !(m_busy[rd] || (pend && prd == rd));
  endfunction

  // Wrapper that captures pre-update state so the error expectation is exact.
  task automatic step(input logic [4:0] q1, input logic [4:0] q2);
    bit ge, gl;
    logic [4:0] rd;
    bit pend;
    logic [4:0] prd;
    pend = m_pend;
    prd = m_pend_rd;
    ge = exu_valid && (!lsu_valid || m_last_lsu);
    gl = lsu_valid && (!exu_valid || !m_last_lsu);
    rd = gl ? lsu_rd : exu_rd;
    if (err_cond(ge, gl, rd, pend, prd)) begin
      tick(q1, q2);
      m_err = 1'b1;
    end else begin
      tick(q1, q2);
    end
  endtask

  function automatic logic [4:0] pick_busy();
    for (int t = 0; t < 6; t++) begin
      logic [4:0] r;
      r = 5'($urandom_range(1, 31));
      if (m_busy[r]) return r;
    end
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    query_rs1 = 5; query_rs2 = 9;
    #1;
    chk("reset_rf_wen", rf_wen, 0);
    chk("reset_rf_waddr", rf_waddr, 0);
    chk("reset_rf_wdata", rf_wdata, 0);
    chk("reset_wb_err", wb_err, 0);
    chk("reset_busy_rs1", busy_rs1, 0);
    chk("reset_busy_rs2", busy_rs2, 0);
    rst_n = 1'b1;

    // Claim x5, then a WAW claim on x5 must stall.
    drive(1, 5, 0, 0, 0, 0, 0, 0); step(5, 0);
    chk("busy5_after_issue", busy_rs1, 1);
    step(5, 0);
    // EXU writes x5; busy drops one edge after the write port fires.
    drive(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0); step(5, 0);
    idle(); step(5, 0);
    chk("busy5_cleared", busy_rs1, 0);
    step(5, 0);

    // Contention: LSU wins first, EXU second.
    drive(1, 3, 0, 0, 0, 0, 0, 0); step(3, 4);
    drive(1, 4, 0, 0, 0, 0, 0, 0); step(3, 4);
    drive(0, 0, 1, 3, 32'h11, 1, 4, 32'h22); step(3, 4);
    step(3, 4);
    idle(); step(3, 4); step(3, 4); step(3, 4);

    // x0 writeback and x0 claim: accepted, nothing written or marked.
    drive(1, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0); step(0, 0);
    idle(); step(0, 0); step(0, 0);

    // Write to a register nobody claimed: still written, error becomes sticky.
    drive(0, 0, 0, 0, 0, 1, 7, 32'h1); step(7, 0);
    idle(); step(7, 0);
    chk("wb_err_set", wb_err, 1);
    drive(1, 12, 0, 0, 0, 0, 0, 0); step(12, 0);
    drive(0, 0, 1, 12, 32'h55, 0, 0, 0); step(12, 0);
    idle(); step(12, 0); step(12, 0);

    // Asynchronous reset during the write-port cycle.
    drive(1, 9, 0, 0, 0, 0, 0, 0); step(9, 0);
    drive(0, 0, 1, 9, 32'hCAFE0009, 0, 0, 0); step(9, 0);
    chk("pre_reset_rf_wen", rf_wen, 1);
    idle();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rf_wen", rf_wen, 0);
    chk("async_busy9", busy_rs1, 0);
    chk("async_wb_err", wb_err, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 9, 0, 0, 0, 0, 0, 0); step(9, 0);
    idle(); step(9, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] er, lr;
      er = pick_busy();
      lr = pick_busy();
      drive($urandom_range(0, 1), 5'($urandom_range(0, 31)),
            $urandom_range(0, 2) == 0, er, $urandom,
            $urandom_range(0, 2) == 0, lr, $urandom);
      step(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    idle();
    repeat (4) step(0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
